// File: rtl/rx_page_ctrl.sv
// rx_page_ctrl: receive page scheduler between the rx byte assembler and the
// host-visible receive page RAM. It owns PAGES pages: one is always the current
// write page (wr_page). Every other page sits either in the free queue or in
// the ready queue, where the host collects it.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   switch       assembler pulse: the current write page holds a finished frame
//   wr_flags     status captured with the frame on switch
//   rd_done      host pulse: the page at rd_page is released
//   clear        pulse: discard everything and return to the reset state
//   wr_page      page the assembler writes (RAM write-address MSBs)
//   rd_page      oldest ready page (RAM read-address MSBs), valid while rx_pending
//   rd_flags     flags stored with rd_page, valid while rx_pending
//   rx_pending   ready queue non-empty (registered)
//   rx_lost      one-cycle pulse per frame dropped for lack of a free page
//   lost_cnt     saturating count of dropped frames
//   free_cnt     pages in the free queue
//   ready_cnt    pages in the ready queue
//
// Handshake: switch, rd_done and clear are single-cycle strobes sampled on the
// rising edge; there is no back-pressure and no busy state, so every strobe is
// consumed on the edge it is seen and its effect is visible the next cycle.
module rx_page_ctrl #(
  parameter  int PAGES = 4,
  localparam int AW    = $clog2(PAGES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          switch,
  input  logic [7:0]    wr_flags,
  input  logic          rd_done,
  input  logic          clear,
  output logic [AW-1:0] wr_page,
  output logic [AW-1:0] rd_page,
  output logic [7:0]    rd_flags,
  output logic          rx_pending,
  output logic          rx_lost,
  output logic [7:0]    lost_cnt,
  output logic [AW:0]   free_cnt,
  output logic [AW:0]   ready_cnt
);

  logic [AW-1:0] free_q  [PAGES];
  logic [AW-1:0] rdy_idx [PAGES];
  logic [7:0]    rdy_flg [PAGES];

  logic [AW-1:0] free_head, free_tail;
  logic [AW-1:0] rdy_head, rdy_tail;

  logic          do_swap;     // switch + release: released page goes straight to the writer
  logic          take_free;   // switch: new write page comes from the free queue
  logic          do_drop;     // switch with nothing free: frame discarded
  logic          rd_ok;       // release only: head page returns to the free queue
  logic          push_ready;
  logic [AW:0]   free_cnt_nxt;
  logic [AW:0]   ready_cnt_nxt;

  always_comb begin
    do_swap       = 1'b0;
    take_free     = 1'b0;
    do_drop       = 1'b0;
    rd_ok         = 1'b0;
    free_cnt_nxt  = free_cnt;
    ready_cnt_nxt = ready_cnt;

    if (switch && rd_done && (ready_cnt != '0)) begin
      do_swap = 1'b1;
    end else if (switch) begin
      if (free_cnt != '0) take_free = 1'b1;
      else                do_drop   = 1'b1;
    end else if (rd_done && (ready_cnt != '0)) begin
      rd_ok = 1'b1;
    end

    if (take_free) begin
      free_cnt_nxt  = free_cnt - 1'b1;
      ready_cnt_nxt = ready_cnt + 1'b1;
    end else if (rd_ok) begin
      free_cnt_nxt  = free_cnt + 1'b1;
      ready_cnt_nxt = ready_cnt - 1'b1;
    end

    push_ready = do_swap || take_free;
  end

  // Head slot is shown even when empty; consumers qualify with rx_pending.
  assign rd_page  = rdy_idx[rdy_head];
  assign rd_flags = rdy_flg[rdy_head];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      // Free queue starts as 1..PAGES-1 from the head; the slot at the tail
      // is empty and gets the 0 filler.
      for (int i = 0; i < PAGES; i++) begin
        free_q[i]  <= AW'((i + 1) % PAGES);
        rdy_idx[i] <= '0;
        rdy_flg[i] <= '0;
      end
      free_head  <= '0;
      free_tail  <= AW'(PAGES - 1);
      free_cnt   <= (AW+1)'(PAGES - 1);
      rdy_head   <= '0;
      rdy_tail   <= '0;
      ready_cnt  <= '0;
      wr_page    <= '0;
      rx_pending <= 1'b0;
      rx_lost    <= 1'b0;
      lost_cnt   <= '0;
    end else begin
      if (push_ready) begin
        rdy_idx[rdy_tail] <= wr_page;
        rdy_flg[rdy_tail] <= wr_flags;
        rdy_tail          <= rdy_tail + 1'b1;
      end
      if (do_swap || rd_ok) rdy_head <= rdy_head + 1'b1;

      if (do_swap) begin
        wr_page <= rdy_idx[rdy_head];
      end else if (take_free) begin
        wr_page   <= free_q[free_head];
        free_head <= free_head + 1'b1;
      end

      if (rd_ok) begin
        free_q[free_tail] <= rdy_idx[rdy_head];
        free_tail         <= free_tail + 1'b1;
      end

      free_cnt   <= free_cnt_nxt;
      ready_cnt  <= ready_cnt_nxt;
      rx_pending <= (ready_cnt_nxt != '0);
      rx_lost    <= do_drop;
      if (do_drop && (lost_cnt != 8'hff)) lost_cnt <= lost_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_page_ctrl.sv
// Directed and random stimulus for rx_page_ctrl with PAGES=4. A queue-based
// reference keeps the free pool, the write page and the ready queue; ready
// entries are pushed when a frame is accepted and popped/compared against
// rd_page/rd_flags when the host releases them.
module tb_rx_page_ctrl;
  localparam int PAGES = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          reset;
  logic          switch;
  logic [7:0]    wr_flags;
  logic          rd_done;
  logic          clear;
  logic [AW-1:0] wr_page;
  logic [AW-1:0] rd_page;
  logic [7:0]    rd_flags;
  logic          rx_pending;
  logic          rx_lost;
  logic [7:0]    lost_cnt;
  logic [AW:0]   free_cnt;
  logic [AW:0]   ready_cnt;

  rx_page_ctrl #(.PAGES(PAGES)) dut (
    .clk        (clk),
    .reset      (reset),
    .switch     (switch),
    .wr_flags   (wr_flags),
    .rd_done    (rd_done),
    .clear      (clear),
    .wr_page    (wr_page),
    .rd_page    (rd_page),
    .rd_flags   (rd_flags),
    .rx_pending (rx_pending),
    .rx_lost    (rx_lost),
    .lost_cnt   (lost_cnt),
    .free_cnt   (free_cnt),
    .ready_cnt  (ready_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference state; exp_q entries are {page, flags}
  logic [AW+7:0] exp_q[$];
  logic [AW-1:0] free_m[$];
  logic [AW-1:0] wr_m;
  logic [7:0]    lost_m;
  logic          lost_pulse_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    exp_q.delete();
    free_m.delete();
    for (int i = 1; i < PAGES; i++) free_m.push_back(AW'(i));
    wr_m         = '0;
    lost_m       = '0;
    lost_pulse_m = 1'b0;
  endtask

  task automatic check_all();
    chk("wr_page",    wr_page,    wr_m);
    chk("free_cnt",   free_cnt,   free_m.size());
    chk("ready_cnt",  ready_cnt,  exp_q.size());
    chk("rx_pending", rx_pending, exp_q.size() != 0);
    chk("rx_lost",    rx_lost,    lost_pulse_m);
    chk("lost_cnt",   lost_cnt,   lost_m);
    if (exp_q.size() != 0) begin
      chk("rd_page",  rd_page,  exp_q[0][AW+7:8]);
      chk("rd_flags", rd_flags, exp_q[0][7:0]);
    end
  endtask

  // driver: one clock with the given strobes, then model update and checks
  task automatic cycle(input logic sw, input logic [7:0] fl, input logic rd, input logic clr);
    logic [AW+7:0] r;
    // scoreboard pop: the released page must be the oldest accepted frame
    if (rd && !clr && exp_q.size() != 0) begin
      chk("release_page",  rd_page,  exp_q[0][AW+7:8]);
      chk("release_flags", rd_flags, exp_q[0][7:0]);
    end
    switch = sw; wr_flags = fl; rd_done = rd; clear = clr;
    @(posedge clk);
    #1;
    switch = 1'b0; wr_flags = '0; rd_done = 1'b0; clear = 1'b0;
    lost_pulse_m = 1'b0;
    if (clr) begin
      model_init();
    end else if (sw && rd && exp_q.size() != 0) begin
      r = exp_q.pop_front();
      exp_q.push_back({wr_m, fl});
      wr_m = r[AW+7:8];
    end else if (sw) begin
      if (free_m.size() != 0) begin
        exp_q.push_back({wr_m, fl});
        wr_m = free_m.pop_front();
      end else begin
        lost_pulse_m = 1'b1;
        if (lost_m != 8'hff) lost_m = lost_m + 1'b1;
      end
    end else if (rd && exp_q.size() != 0) begin
      r = exp_q.pop_front();
      free_m.push_back(r[AW+7:8]);
    end
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();
    check_all();
  endtask

  task automatic check_initial(input string tag);
    chk({tag, "_wr_page"},   wr_page,    0);
    chk({tag, "_free_cnt"},  free_cnt,   3);
    chk({tag, "_ready_cnt"}, ready_cnt,  0);
    chk({tag, "_pending"},   rx_pending, 0);
    chk({tag, "_lost_cnt"},  lost_cnt,   0);
    chk({tag, "_rx_lost"},   rx_lost,    0);
  endtask

  initial begin
    reset = 1'b1; switch = 1'b0; wr_flags = '0; rd_done = 1'b0; clear = 1'b0;
    model_init();
    repeat (2) @(posedge clk);
    do_reset();
    check_initial("reset");

    // fill: three frames with an idle gap between them
    cycle(1, 8'h00, 0, 0); cycle(0, 8'h00, 0, 0);
    chk("fill1_wr_page", wr_page, 1);
    cycle(1, 8'h12, 0, 0); cycle(0, 8'h00, 0, 0);
    chk("fill2_wr_page", wr_page, 2);
    cycle(1, 8'h00, 0, 0); cycle(0, 8'h00, 0, 0);
    chk("fill3_wr_page", wr_page, 3);
    chk("full_ready_cnt", ready_cnt, 3);
    chk("full_free_cnt",  free_cnt,  0);
    chk("full_rd_page",   rd_page,   0);
    chk("full_rd_flags",  rd_flags,  8'h00);

    // drop from full, then saturate the lost counter
    cycle(1, 8'h77, 0, 0);
    chk("drop_rx_lost",  rx_lost,  1);
    chk("drop_lost_cnt", lost_cnt, 1);
    chk("drop_wr_page",  wr_page,  3);
    cycle(0, 8'h00, 0, 0);
    chk("drop_pulse_end", rx_lost, 0);
    for (int i = 0; i < 300; i++) cycle(1, 8'(i), 0, 0);
    chk("lost_saturated", lost_cnt, 8'hff);
    cycle(0, 8'h00, 0, 0);

    // switch + release together from full: head page 0 goes to the writer
    cycle(1, 8'h55, 1, 0);
    chk("swap_wr_page",  wr_page,  0);
    chk("swap_rx_lost",  rx_lost,  0);
    chk("swap_free_cnt", free_cnt, 0);
    chk("swap_rd_page",  rd_page,  1);
    chk("swap_rd_flags", rd_flags, 8'h12);

    // drain in order 1,2,3 (old write page with 0x55)
    cycle(0, 8'h00, 1, 0);
    chk("drain1_free_cnt", free_cnt, 1);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    chk("drain_ready_cnt", ready_cnt, 0);

    // release with empty ready queue is ignored
    cycle(0, 8'h00, 1, 0);
    chk("empty_rd_free_cnt", free_cnt, 3);
    chk("empty_rd_wr_page",  wr_page,  0);

    // random traffic, including back-to-back strobes and occasional clear
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 45, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 40, $urandom_range(0, 99) == 0);
    end

    // clear together with switch while two frames are queued
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'h01, 0, 0);
    cycle(1, 8'h02, 0, 0);
    chk("pre_clear_ready_cnt", ready_cnt, 2);
    cycle(1, 8'h03, 0, 1);
    check_initial("clear");

    // reset in the middle of traffic
    cycle(1, 8'h09, 0, 0);
    cycle(1, 8'h0a, 0, 0);
    do_reset();
    check_initial("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
